ee457_fetch_ctrl: RTL and testbench
===================================

Name: ee457_fetch_ctrl

Overview:
Fetch-side consumer of the hazard-detection outputs (stall, pcwrite, irwrite) in the 5-stage EE457 pipeline. It owns the PC register and the IF/ID pipeline register, and drives the ID/EX bubble request. It also handles EX-stage taken-branch redirects and instruction-memory wait states, and maintains saturating stall and flush performance counters.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on a bubble or squash.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  load-use stall from the hazard detection unit
pcwrite  input  1  PC write enable from the hazard detection unit
irwrite  input  1  IF/ID write enable from the hazard detection unit
ex_branch_taken  input  1  branch resolved taken in EX this cycle
ex_branch_target  input  32  redirect address for the taken branch
id_halt  input  1  valid HALT instruction decoded in ID
imem_rdy  input  1  instruction memory returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
imem_req  output  1  fetch request
imem_addr  output  32  fetch address; always equals pc
pc  output  32  current PC
id_instr  output  32  IF/ID instruction
id_pc4  output  32  IF/ID PC+4
id_valid  output  1  IF/ID holds a real instruction
idex_bubble  output  1  zero the control fields of ID/EX this cycle
halted  output  1  FSM is in HALTED
stall_cnt  output  CNT_W  saturating count of stall cycles
flush_cnt  output  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Reset (asynchronous, takes effect immediately): pc=PC_RESET, id_instr=NOP_INSTR, id_pc4=0, id_valid=0, stall_cnt=0, flush_cnt=0, state=BOOT. Combinational outputs while rst=1: imem_req=0, idex_bubble=0, halted=0.
- FSM has three states:
  - BOOT: imem_req=0 and no register updates. Always moves to RUN on the next edge, giving one dead cycle after reset release.
  - RUN: imem_req=1. Moves to HALTED on an edge where id_halt=1 and ex_branch_taken=0. A taken branch cancels the halt because it is on the wrong path.
  - HALTED: imem_req=0, halted=1, pc holds. IF/ID loads NOP_INSTR with id_valid=0 every cycle. Only rst leaves this state.
- RUN-state next-state priority, evaluated per edge, first match wins:
  1. ex_branch_taken=1: pc<=ex_branch_target; IF/ID<=NOP_INSTR with id_valid=0; flush_cnt++. The stall, pcwrite and irwrite inputs are ignored.
  2. stall=1: pc holds if pcwrite=0; IF/ID holds if irwrite=0; stall_cnt++.
  3. imem_rdy=0: pc holds; IF/ID<=NOP_INSTR with id_valid=0 (fetch bubble).
  4. Otherwise: pc<=pc+4; id_instr<=imem_rdata; id_pc4<=pc+4; id_valid<=1.
- pcwrite=0 or irwrite=0 without stall=1 is treated per signal: the corresponding register holds and the lower-priority cases apply to everything else.
- idex_bubble = state==RUN & (stall | ex_branch_taken). It is combinational with zero latency.
- PC arithmetic is modulo 2^32: pc+4 from 32'hFFFF_FFFC wraps to 0. Bits [1:0] of ex_branch_target are forced to 0 when loaded.
- Counters saturate at all-ones and never wrap. They count only in RUN.
- Latency: the instruction at pc appears on id_instr one edge after imem_rdy=1.

Test Plan:
- Reset release with imem_rdy=1 and sequential words A, B, C: one BOOT cycle with imem_req=0, then pc=0, 4, 8. id_instr shows A, then B (id_pc4=4, then 8), with id_valid=1.
- Load-use stall, stall=1 and pcwrite=irwrite=0 for 1 cycle at pc=8: pc stays 8 and id_instr holds, idex_bubble=1 that cycle, then resume at pc=12; stall_cnt=1.
- Taken branch to 32'h0000_0103 at pc=20: next pc=32'h0000_0100, id_valid=0, id_instr=NOP_INSTR, idex_bubble=1, flush_cnt=1.
- stall=1 and ex_branch_taken=1 together, target 0x40: pc=0x40, IF/ID squashed, stall_cnt unchanged, flush_cnt incremented.
- imem_rdy low for 3 cycles at pc=0x10: pc stays 0x10, id_valid=0 for 3 cycles, then the fetch completes. Assert rst mid-wait: pc=PC_RESET immediately and state returns to BOOT.
- id_halt=1: halted=1 and imem_req=0 next cycle, pc frozen indefinitely. With CNT_W=2 and 5 stall cycles, stall_cnt=3 (saturated).

Source files
------------

// File: rtl/ee457_fetch_ctrl.sv
// Fetch-side controller for the EE457 5-stage pipeline: owns the PC and IF/ID
// register, reacts to hazard-unit stalls, EX branch redirects, imem waits and HALT.
module ee457_fetch_ctrl #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pcwrite,
    input  logic             irwrite,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             id_halt,
    input  logic             imem_rdy,
    input  logic [31:0]      imem_rdata,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] pc_nxt;
    logic [31:0] id_instr_nxt;
    logic [31:0] id_pc4_nxt;
    logic        id_valid_nxt;
    logic        stall_inc;
    logic        flush_inc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (id_halt && !ex_branch_taken) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        imem_req    = (state == RUN);
        halted      = (state == HALTED);
        idex_bubble = (state == RUN) && (stall || ex_branch_taken);
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // pcwrite/irwrite gate their own register independently; stall itself
    // only feeds the bubble request and the stall counter.
    always_comb begin
        // NOTE: every output of this block gets a hold value first, so no
        // path through the case statement can infer a latch.
        pc_nxt       = pc;
        id_instr_nxt = id_instr;
        id_pc4_nxt   = id_pc4;
        id_valid_nxt = id_valid;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    pc_nxt       = ex_branch_target & ~32'd3;
                    id_instr_nxt = NOP_INSTR;
                    id_valid_nxt = 1'b0;
                    flush_inc    = 1'b1;
                end else begin
                    stall_inc = stall;
                    if (pcwrite && imem_rdy) pc_nxt = pc_plus4;
                    if (irwrite) begin
                        if (imem_rdy) begin
                            id_instr_nxt = imem_rdata;
                            id_pc4_nxt   = pc_plus4;
                            id_valid_nxt = 1'b1;
                        end else begin
                            id_instr_nxt = NOP_INSTR;
                            id_valid_nxt = 1'b0;
                        end
                    end
                end
            end
            HALTED: begin
                id_instr_nxt = NOP_INSTR;
                id_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= PC_RESET;
            id_instr <= NOP_INSTR;
            id_pc4   <= 32'd0;
            id_valid <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            id_instr <= id_instr_nxt;
            id_pc4   <= id_pc4_nxt;
            id_valid <= id_valid_nxt;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ee457_fetch_ctrl.sv
// Bench for ee457_fetch_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the fetch stage.
module tb_ee457_fetch_ctrl;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, pcwrite, irwrite, ex_branch_taken, id_halt, imem_rdy;
    logic [31:0] ex_branch_target, imem_rdata;

    logic        imem_req, id_valid, idex_bubble, halted;
    logic [31:0] imem_addr, pc, id_instr, id_pc4;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_imem_req, s_id_valid, s_idex_bubble, s_halted;
    logic [31:0] s_imem_addr, s_pc, s_id_instr, s_id_pc4;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the fetch stage.
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid, m_boot, m_halted;
    int          m_stall, m_flush;

    ee457_fetch_ctrl #(.PC_RESET(PC_RST), .NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pcwrite(pcwrite), .irwrite(irwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .id_halt(id_halt), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .id_instr(id_instr),
        .id_pc4(id_pc4), .id_valid(id_valid), .idex_bubble(idex_bubble),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ee457_fetch_ctrl #(.PC_RESET(PC_RST), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .pcwrite(pcwrite), .irwrite(irwrite),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .id_halt(id_halt), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .imem_req(s_imem_req), .imem_addr(s_imem_addr), .pc(s_pc), .id_instr(s_id_instr),
        .id_pc4(s_id_pc4), .id_valid(s_id_valid), .idex_bubble(s_idex_bubble),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        m_pc = PC_RST; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
        m_stall = 0; m_flush = 0; m_boot = 1'b1; m_halted = 1'b0;
    endtask

    // Applies inputs shortly after a rising edge and lets combinational outputs settle.
    task automatic drive(input bit st, input bit pw, input bit iw, input bit br,
                         input logic [31:0] tgt, input bit hlt, input bit rdy,
                         input logic [31:0] rd);
        stall = st; pcwrite = pw; irwrite = iw; ex_branch_taken = br;
        ex_branch_target = tgt; id_halt = hlt; imem_rdy = rdy; imem_rdata = rd;
        #1;
    endtask

    // Advances the model by the rules of one edge, then the clock.
    task automatic tick();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            m_instr = NOP; m_valid = 1'b0;
        end else begin
            if (ex_branch_taken) begin
                m_pc = ex_branch_target & ~32'h3;
                m_instr = NOP; m_valid = 1'b0; m_flush++;
            end else begin
                if (stall) m_stall++;
                if (irwrite) begin
                    if (imem_rdy) begin
                        m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                    end else begin
                        m_instr = NOP; m_valid = 1'b0;
                    end
                end
                if (pcwrite && imem_rdy) m_pc = m_pc + 32'd4;
            end
            if (id_halt && !ex_branch_taken) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
        vectors++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 1, 32'h40, 1, 1, 32'h1234_5678);
        vectors++;
        if (pc !== PC_RST)      begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, PC_RST); end
        if (id_instr !== NOP)   begin miscompares++; $display("FAIL reset_instr: got %h expected %h", id_instr, NOP); end
        if (id_pc4 !== 32'd0)   begin miscompares++; $display("FAIL reset_pc4: got %h expected 0", id_pc4); end
        if (id_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
        if ({imem_req, idex_bubble, halted} !== 3'b000)
            begin miscompares++; $display("FAIL reset_comb: got req/bub/halt %b expected 000", {imem_req, idex_bubble, halted}); end
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            begin miscompares++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        release_reset();
    endtask

    task automatic test_fetch();
        drive(0, 1, 1, 0, 0, 0, 1, 32'hAAAA_0001);
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req: got %b expected 0", imem_req); end
        tick();
        if (pc !== 32'h0 || id_valid !== 1'b0) begin miscompares++; $display("FAIL boot_hold: got pc %h valid %b expected 0/0", pc, id_valid); end
        drive(0, 1, 1, 0, 0, 0, 1, 32'hAAAA_0001);
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL run_req: got %b addr %h expected 1/0", imem_req, imem_addr); end
        tick();
        if (pc !== 32'h4 || id_instr !== 32'hAAAA_0001 || id_pc4 !== 32'h4 || id_valid !== 1'b1)
            begin miscompares++; $display("FAIL fetch_a: got pc %h instr %h pc4 %h v %b expected 4/aaaa0001/4/1", pc, id_instr, id_pc4, id_valid); end
        drive(0, 1, 1, 0, 0, 0, 1, 32'hBBBB_0002);
        tick();
        if (pc !== 32'h8 || id_instr !== 32'hBBBB_0002 || id_pc4 !== 32'h8)
            begin miscompares++; $display("FAIL fetch_b: got pc %h instr %h pc4 %h expected 8/bbbb0002/8", pc, id_instr, id_pc4); end
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0, 0, 1, 32'hCCCC_0003);
        if (idex_bubble !== 1'b1) begin miscompares++; $display("FAIL stall_bubble: got %b expected 1", idex_bubble); end
        tick();
        if (pc !== 32'h8 || id_instr !== 32'hBBBB_0002 || stall_cnt !== 16'd1)
            begin miscompares++; $display("FAIL stall_hold: got pc %h instr %h cnt %0d expected 8/bbbb0002/1", pc, id_instr, stall_cnt); end
        drive(0, 1, 1, 0, 0, 0, 1, 32'hCCCC_0003);
        if (idex_bubble !== 1'b0) begin miscompares++; $display("FAIL resume_bubble: got %b expected 0", idex_bubble); end
        tick();
        if (pc !== 32'hC || id_instr !== 32'hCCCC_0003 || id_pc4 !== 32'hC)
            begin miscompares++; $display("FAIL resume: got pc %h instr %h pc4 %h expected c/cccc0003/c", pc, id_instr, id_pc4); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 0, 0, 1, 32'hD000_0000 + i);
            tick();
        end
    endtask

    task automatic test_branch();
        if (pc !== 32'h14) begin miscompares++; $display("FAIL pre_branch_pc: got %h expected 14", pc); end
        drive(0, 1, 1, 1, 32'h0000_0103, 0, 1, 32'hEEEE_EEEE);
        if (idex_bubble !== 1'b1) begin miscompares++; $display("FAIL branch_bubble: got %b expected 1", idex_bubble); end
        tick();
        if (pc !== 32'h100 || id_valid !== 1'b0 || id_instr !== NOP || flush_cnt !== 16'd1)
            begin miscompares++; $display("FAIL branch: got pc %h v %b instr %h fl %0d expected 100/0/%h/1", pc, id_valid, id_instr, flush_cnt, NOP); end
        drive(1, 0, 0, 1, 32'h0000_0040, 0, 1, 32'hEEEE_EEEE);
        tick();
        if (pc !== 32'h40 || id_valid !== 1'b0 || stall_cnt !== 16'd1 || flush_cnt !== 16'd2)
            begin miscompares++; $display("FAIL stall_branch: got pc %h v %b st %0d fl %0d expected 40/0/1/2", pc, id_valid, stall_cnt, flush_cnt); end
    endtask

    task automatic test_imem_wait();
        drive(0, 1, 1, 1, 32'h10, 0, 1, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 0, 0, 32'h9999_0000 + i);
            tick();
            if (pc !== 32'h10 || id_valid !== 1'b0 || id_instr !== NOP)
                begin miscompares++; $display("FAIL wait_%0d: got pc %h v %b instr %h expected 10/0/nop", i, pc, id_valid, id_instr); end
        end
        drive(0, 1, 1, 0, 0, 0, 1, 32'h1111_0010);
        tick();
        if (pc !== 32'h14 || id_instr !== 32'h1111_0010 || id_pc4 !== 32'h14 || id_valid !== 1'b1)
            begin miscompares++; $display("FAIL wait_done: got pc %h instr %h pc4 %h v %b expected 14/11110010/14/1", pc, id_instr, id_pc4, id_valid); end
        drive(1, 1, 1, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;
        #1;
        if (pc !== PC_RST || imem_req !== 1'b0 || idex_bubble !== 1'b0 || stall_cnt !== 16'd0)
            begin miscompares++; $display("FAIL async_rst: got pc %h req %b bub %b st %0d expected %h/0/0/0", pc, imem_req, idex_bubble, stall_cnt, PC_RST); end
        release_reset();
        drive(0, 1, 1, 0, 0, 0, 1, 32'h2222_2222);
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reboot_req: got %b expected 0", imem_req); end
        tick();
        if (pc !== PC_RST || id_valid !== 1'b0) begin miscompares++; $display("FAIL reboot_hold: got pc %h v %b expected 0/0", pc, id_valid); end
    endtask

    task automatic test_wrap();
        drive(0, 1, 1, 1, 32'hFFFF_FFFF, 0, 1, 32'h0);
        tick();
        if (pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL target_mask: got %h expected fffffffc", pc); end
        drive(0, 1, 1, 0, 0, 0, 1, 32'h3333_0003);
        tick();
        if (pc !== 32'h0 || id_pc4 !== 32'h0 || id_instr !== 32'h3333_0003)
            begin miscompares++; $display("FAIL wrap: got pc %h pc4 %h instr %h expected 0/0/33330003", pc, id_pc4, id_instr); end
    endtask

    task automatic test_halt();
        drive(0, 1, 1, 1, 32'h80, 1, 1, 32'h0);
        tick();
        if (halted !== 1'b0 || pc !== 32'h80) begin miscompares++; $display("FAIL halt_cancel: got halted %b pc %h expected 0/80", halted, pc); end
        drive(0, 1, 1, 0, 0, 1, 1, 32'h4444_0004);
        tick();
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h84 || id_instr !== 32'h4444_0004)
            begin miscompares++; $display("FAIL halt_enter: got h %b req %b pc %h instr %h expected 1/0/84/44440004", halted, imem_req, pc, id_instr); end
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, bit'($urandom_range(1)), $urandom, 0, 1, $urandom);
            if (halted !== 1'b1 || imem_req !== 1'b0 || idex_bubble !== 1'b0)
                begin miscompares++; $display("FAIL halted_comb_%0d: got h/req/bub %b expected 100", i, {halted, imem_req, idex_bubble}); end
            tick();
            if (pc !== 32'h84 || id_valid !== 1'b0 || id_instr !== NOP || stall_cnt !== 16'd0 || flush_cnt !== 16'd2)
                begin miscompares++; $display("FAIL halted_%0d: got pc %h v %b instr %h st %0d fl %0d expected 84/0/nop/0/2", i, pc, id_valid, id_instr, stall_cnt, flush_cnt); end
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        release_reset();
        drive(0, 1, 1, 0, 0, 0, 1, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 1, 32'h0);
            tick();
        end
        if (stall_cnt !== 16'd5 || s_stall_cnt !== 2'd3)
            begin miscompares++; $display("FAIL stall_sat: got %0d/%0d expected 5/3", stall_cnt, s_stall_cnt); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 1, 32'h200, 0, 1, 32'h0);
            tick();
        end
        if (flush_cnt !== 16'd5 || s_flush_cnt !== 2'd3 || s_stall_cnt !== 2'd3)
            begin miscompares++; $display("FAIL flush_sat: got %0d/%0d st %0d expected 5/3/3", flush_cnt, s_flush_cnt, s_stall_cnt); end
    endtask

    task automatic test_random();
        bit st, br;
        int halted_for;
        rst = 1'b1;
        release_reset();
        halted_for = 0;
        for (int n = 0; n < 3000; n++) begin
            if ((m_halted && halted_for > 12) || $urandom_range(399) == 0) begin
                rst = 1'b1;
                release_reset();
                halted_for = 0;
            end
            st = ($urandom_range(3) == 0);
            br = ($urandom_range(7) == 0);
            drive(st, $urandom_range(4) != 0, $urandom_range(4) != 0, br, $urandom,
                  $urandom_range(119) == 0, $urandom_range(3) != 0, $urandom);
            if ({imem_req, halted, idex_bubble} !== {!m_boot && !m_halted, m_halted, !m_boot && !m_halted && (st || br)} ||
                imem_addr !== m_pc)
                begin miscompares++; $display("FAIL rnd_comb_%0d: got req/h/bub %b addr %h expected %b %h", n, {imem_req, halted, idex_bubble},
                      imem_addr, {!m_boot && !m_halted, m_halted, !m_boot && !m_halted && (st || br)}, m_pc); end
            if ({s_imem_req, s_halted, s_idex_bubble} !== {!m_boot && !m_halted, m_halted, !m_boot && !m_halted && (st || br)} ||
                s_imem_addr !== m_pc)
                begin miscompares++; $display("FAIL rnd_sat_comb_%0d: got %b addr %h expected addr %h", n, {s_imem_req, s_halted, s_idex_bubble}, s_imem_addr, m_pc); end
            tick();
            if (m_halted) halted_for++;
            if (pc !== m_pc || id_instr !== m_instr || id_valid !== m_valid || (m_valid && id_pc4 !== m_pc4))
                begin miscompares++; $display("FAIL rnd_regs_%0d: got pc %h instr %h v %b pc4 %h expected %h %h %b %h", n, pc, id_instr, id_valid, id_pc4, m_pc, m_instr, m_valid, m_pc4); end
            if (32'(stall_cnt) !== sat(m_stall, 16) || 32'(flush_cnt) !== sat(m_flush, 16))
                begin miscompares++; $display("FAIL rnd_cnt_%0d: got %0d/%0d expected %0d/%0d", n, stall_cnt, flush_cnt, sat(m_stall, 16), sat(m_flush, 16)); end
            if (s_pc !== m_pc || s_id_instr !== m_instr || s_id_valid !== m_valid || (m_valid && s_id_pc4 !== m_pc4) ||
                32'(s_stall_cnt) !== sat(m_stall, 2) || 32'(s_flush_cnt) !== sat(m_flush, 2))
                begin miscompares++; $display("FAIL rnd_sat_%0d: got pc %h cnt %0d/%0d expected %h %0d/%0d", n, s_pc, s_stall_cnt, s_flush_cnt, m_pc, sat(m_stall, 2), sat(m_flush, 2)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(0, 1, 1, 0, 0, 0, 1, 32'h0);
        test_reset();
        test_fetch();
        test_load_use();
        test_branch();
        test_imem_wait();
        test_wrap();
        test_halt();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
